// File: rtl/doe_ctrl_pkg.sv
// ============================================================================
//  Module   : doe_ctrl_pkg
//  Purpose  : Shared types and constants for the DOE core command sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package doe_ctrl_pkg;

  typedef enum logic [1:0] {
    DOE_OP_INIT = 2'd0,
    DOE_OP_ENC  = 2'd1,
    DOE_OP_DEC  = 2'd2
  } doe_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_K_START = 3'd1,
    ST_K_ARM   = 3'd2,
    ST_K_WAIT  = 3'd3,
    ST_B_START = 3'd4,
    ST_B_ARM   = 3'd5,
    ST_B_WAIT  = 3'd6,
    ST_RESP    = 3'd7
  } doe_state_e;

  localparam logic DOE_128_BIT_KEY = 1'b0;
  localparam logic DOE_256_BIT_KEY = 1'b1;

  localparam int unsigned DOE_CNT_W = 6;

  function automatic logic is_key_state(input doe_state_e s);
    return (s == ST_K_START) || (s == ST_K_ARM) || (s == ST_K_WAIT);
  endfunction

  function automatic logic is_blk_state(input doe_state_e s);
    return (s == ST_B_START) || (s == ST_B_ARM) || (s == ST_B_WAIT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/doe_sbox_arb.sv
// ============================================================================
//  Module   : doe_sbox_arb
//  Purpose  : Combinational arbiter for the shared S-box and key round port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module doe_sbox_arb
  import doe_ctrl_pkg::*;
(
  input  doe_state_e  state,
  input  doe_op_e     op,
  input  logic [3:0]  enc_round,
  input  logic [3:0]  dec_round,
  input  logic [31:0] km_sboxw,
  input  logic [31:0] enc_sboxw,
  input  logic [31:0] dec_sboxw,
  output logic [3:0]  km_round,
  output logic [31:0] sbox_in
);

  logic w_dec_active;

  assign w_dec_active = is_blk_state(state) && (op == DOE_OP_DEC);

  always_comb begin
    km_round = enc_round;
    sbox_in  = enc_sboxw;
    if (is_key_state(state)) begin
      sbox_in = km_sboxw;
    end else if (w_dec_active) begin
      sbox_in  = dec_sboxw;
      km_round = dec_round;
    end
  end

endmodule

`default_nettype wire

// File: rtl/doe_core_ctrl.sv
// ============================================================================
//  Module   : doe_core_ctrl
//  Purpose  : Command sequencer for key expansion and block processing.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module doe_core_ctrl
  import doe_ctrl_pkg::*;
#(
  parameter int unsigned KEY_TIMEOUT = 31,
  parameter int unsigned BLK_TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        zeroize,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_keylen,
  output logic        rsp_valid,
  output logic        rsp_error,
  output logic        key_valid,
  output logic        busy,
  output logic        km_init,
  output logic        km_keylen,
  input  logic        km_ready,
  output logic        km_zeroize,
  output logic        enc_next,
  output logic        dec_next,
  input  logic        enc_ready,
  input  logic        dec_ready,
  input  logic [3:0]  enc_round,
  input  logic [3:0]  dec_round,
  output logic [3:0]  km_round,
  input  logic [31:0] km_sboxw,
  input  logic [31:0] enc_sboxw,
  input  logic [31:0] dec_sboxw,
  output logic [31:0] sbox_in
);

  // Timeout fires on the cycle whose successor would see the counter at the limit.
  localparam logic [DOE_CNT_W-1:0] KEY_LAST = DOE_CNT_W'(KEY_TIMEOUT - 1);
  localparam logic [DOE_CNT_W-1:0] BLK_LAST = DOE_CNT_W'(BLK_TIMEOUT - 1);

  doe_state_e           state_q, state_d;
  doe_op_e              op_q, op_d;
  logic                 keylen_q, keylen_d;
  logic                 key_valid_q, key_valid_d;
  logic                 err_q, err_d;
  logic [DOE_CNT_W-1:0] cnt_q, cnt_d;
  logic                 w_eng_ready;

  assign w_eng_ready = (op_q == DOE_OP_DEC) ? dec_ready : enc_ready;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    keylen_d    = keylen_q;
    key_valid_d = key_valid_q;
    err_d       = 1'b0;
    cnt_d       = cnt_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            DOE_OP_INIT: begin
              keylen_d    = (cmd_keylen == DOE_256_BIT_KEY) ? DOE_256_BIT_KEY
                                                            : DOE_128_BIT_KEY;
              key_valid_d = 1'b0;
              cnt_d       = '0;
              state_d     = ST_K_START;
            end
            DOE_OP_ENC, DOE_OP_DEC: begin
              if (key_valid_q) begin
                op_d    = doe_op_e'(cmd_op);
                cnt_d   = '0;
                state_d = ST_B_START;
              end else begin
                err_d   = 1'b1;
                state_d = ST_RESP;
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = ST_RESP;
            end
          endcase
        end
      end
      ST_K_START: state_d = ST_K_ARM;
      ST_K_ARM:   state_d = ST_K_WAIT;
      ST_K_WAIT: begin
        if (km_ready) begin
          key_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (cnt_q == KEY_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_B_START: state_d = ST_B_ARM;
      ST_B_ARM:   state_d = ST_B_WAIT;
      ST_B_WAIT: begin
        if (w_eng_ready) begin
          state_d = ST_RESP;
        end else if (cnt_q == BLK_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Zeroize wipes the block exactly like reset, including the key state.
  always_ff @(posedge clk) begin
    if (reset || zeroize) begin
      state_q     <= ST_IDLE;
      op_q        <= DOE_OP_INIT;
      keylen_q    <= DOE_128_BIT_KEY;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      keylen_q    <= keylen_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_error  = err_q;
  assign key_valid  = key_valid_q;
  assign km_init    = (state_q == ST_K_START);
  assign km_keylen  = keylen_q;
  assign km_zeroize = zeroize;
  assign enc_next   = (state_q == ST_B_START) && (op_q == DOE_OP_ENC);
  assign dec_next   = (state_q == ST_B_START) && (op_q == DOE_OP_DEC);

  doe_sbox_arb u_sbox_arb (
    .state     (state_q),
    .op        (op_q),
    .enc_round (enc_round),
    .dec_round (dec_round),
    .km_sboxw  (km_sboxw),
    .enc_sboxw (enc_sboxw),
    .dec_sboxw (dec_sboxw),
    .km_round  (km_round),
    .sbox_in   (sbox_in)
  );

endmodule

`default_nettype wire

// File: tb/tb_doe_core_ctrl.sv
// ============================================================================
//  Module   : tb_doe_core_ctrl
//  Purpose  : Directed self-checking bench for doe_core_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_doe_core_ctrl;

  localparam int KM_LAT  = 19;  // km_ready 19 cycles after the init cycle
  localparam int ENC_LAT = 5;
  localparam int DEC_LAT = 11;  // dec_ready 12 cycles after the pulse cycle

  logic        clk = 1'b0;
  logic        reset, zeroize;
  logic        cmd_valid, cmd_ready, cmd_keylen;
  logic [1:0]  cmd_op;
  logic        rsp_valid, rsp_error, key_valid, busy;
  logic        km_init, km_keylen, km_ready, km_zeroize;
  logic        enc_next, dec_next, enc_ready, dec_ready;
  logic [3:0]  enc_round, dec_round, km_round;
  logic [31:0] km_sboxw, enc_sboxw, dec_sboxw, sbox_in;

  int n_checks = 0;
  int n_errors = 0;

  doe_core_ctrl #(.KEY_TIMEOUT(31), .BLK_TIMEOUT(63)) dut (
    .clk(clk), .reset(reset), .zeroize(zeroize),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_keylen(cmd_keylen), .rsp_valid(rsp_valid), .rsp_error(rsp_error),
    .key_valid(key_valid), .busy(busy), .km_init(km_init),
    .km_keylen(km_keylen), .km_ready(km_ready), .km_zeroize(km_zeroize),
    .enc_next(enc_next), .dec_next(dec_next), .enc_ready(enc_ready),
    .dec_ready(dec_ready), .enc_round(enc_round), .dec_round(dec_round),
    .km_round(km_round), .km_sboxw(km_sboxw), .enc_sboxw(enc_sboxw),
    .dec_sboxw(dec_sboxw), .sbox_in(sbox_in)
  );

  always #5 clk = ~clk;

  // Key memory and engine models.
  int km_cnt = 0, enc_cnt = 0, dec_cnt = 0;
  bit km_hold = 1'b0;
  assign km_ready  = !km_hold && (km_cnt >= KM_LAT);
  assign enc_ready = (enc_cnt == 0);
  assign dec_ready = (dec_cnt == 0);

  always @(posedge clk) begin
    if (reset || km_zeroize) km_cnt <= 0;
    else if (km_init) km_cnt <= 1;
    else if (km_cnt != 0 && km_cnt < 40) km_cnt <= km_cnt + 1;
    if (reset) enc_cnt <= 0;
    else if (enc_next) enc_cnt <= ENC_LAT;
    else if (enc_cnt != 0) enc_cnt <= enc_cnt - 1;
    if (reset) dec_cnt <= 0;
    else if (dec_next) dec_cnt <= DEC_LAT;
    else if (dec_cnt != 0) dec_cnt <= dec_cnt - 1;
  end

  // Event monitor; cycle numbers follow "cycle k ends at edge k".
  int cyc = 0;
  int acc_count = 0, acc_edge = 0;
  int rsp_count = 0, rsp_cyc = 0;
  int km_init_count = 0, km_init_cyc = 0;
  int enc_pulses = 0, dec_pulses = 0;
  logic rsp_err_s = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #2;
    if (cmd_valid && cmd_ready && !reset && !zeroize) begin
      acc_count <= acc_count + 1;
      acc_edge  <= cyc + 1;
    end
    if (rsp_valid) begin
      rsp_count <= rsp_count + 1;
      rsp_cyc   <= cyc + 1;
      rsp_err_s <= rsp_error;
    end
    if (km_init) begin
      km_init_count <= km_init_count + 1;
      km_init_cyc   <= cyc + 1;
    end
    if (enc_next) enc_pulses <= enc_pulses + 1;
    if (dec_next) dec_pulses <= dec_pulses + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic kl, input bit hold);
    @(negedge clk);
    cmd_op = op; cmd_keylen = kl; cmd_valid = 1'b1;
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    #1;
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    int r0;
    bit seen;
    r0 = rsp_count;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #3;
      if (rsp_count != r0) seen = 1'b1;
    end
    if (!seen) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, d0, k0, a0, r0, bad;
    reset = 1'b1; zeroize = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_keylen = 1'b0;
    enc_round = 4'h3; dec_round = 4'hC;
    km_sboxw = 32'hAAAA_0001; enc_sboxw = 32'hEEEE_0002; dec_sboxw = 32'hDDDD_0003;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_key_valid", key_valid, 0);
    check_eq("rst_outs", {rsp_valid, rsp_error, km_init, km_keylen, enc_next, dec_next}, 0);
    check_eq("rst_sbox", sbox_in, 32'hEEEE_0002);
    check_eq("rst_round", km_round, 4'h3);

    // ENC with no key: immediate error, no engine pulse.
    e0 = enc_pulses;
    issue(2'd1, 1'b0, 1'b0);
    check_eq("nokey_rsp_valid", rsp_valid, 1);
    check_eq("nokey_rsp_error", rsp_error, 1);
    @(negedge clk); #1;
    check_eq("nokey_cmd_ready", cmd_ready, 1);
    check_eq("nokey_enc_pulses", enc_pulses - e0, 0);
    check_eq("nokey_key_valid", key_valid, 0);

    // INIT_KEY, 256-bit.
    k0 = km_init_count;
    issue(2'd0, 1'b1, 1'b0);
    check_eq("init_km_init_n1", km_init, 1);
    check_eq("init_sbox_n1", sbox_in, 32'hAAAA_0001);
    check_eq("init_keylen", km_keylen, 1);
    check_eq("init_cmd_ready", cmd_ready, 0);
    @(negedge clk); #1;
    check_eq("init_km_init_n2", km_init, 0);
    check_eq("init_sbox_n2", sbox_in, 32'hAAAA_0001);
    wait_rsp("init", 40);
    check_eq("init_rsp_lat", rsp_cyc - acc_edge, 21);
    check_eq("init_rsp_err", rsp_err_s, 0);
    check_eq("init_key_valid", key_valid, 1);
    check_eq("init_km_pulses", km_init_count - k0, 1);

    // DEC with a 12-cycle engine.
    e0 = enc_pulses; d0 = dec_pulses;
    issue(2'd2, 1'b0, 1'b0);
    check_eq("dec_next_n1", dec_next, 1);
    check_eq("dec_round_n1", km_round, 4'hC);
    check_eq("dec_sbox_n1", sbox_in, 32'hDDDD_0003);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (km_round !== 4'hC || sbox_in !== 32'hDDDD_0003) bad++;
    end
    check_eq("dec_mux_hold", bad, 0);
    wait_rsp("dec", 10);
    check_eq("dec_rsp_lat", rsp_cyc - acc_edge, DEC_LAT + 3);
    check_eq("dec_rsp_err", rsp_err_s, 0);
    check_eq("dec_pulses", dec_pulses - d0, 1);
    check_eq("dec_enc_pulses", enc_pulses - e0, 0);

    // Key timeout with km_ready held low.
    km_hold = 1'b1;
    issue(2'd0, 1'b1, 1'b0);
    check_eq("kto_key_cleared", key_valid, 0);
    wait_rsp("kto", 50);
    check_eq("kto_rsp_lat", rsp_cyc - km_init_cyc, 31);
    check_eq("kto_rsp_err", rsp_err_s, 1);
    check_eq("kto_key_valid", key_valid, 0);

    // Zeroize in K_WAIT while a command is held.
    issue(2'd0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    @(negedge clk);
    zeroize = 1'b1;
    #1;
    check_eq("zer_km_zeroize", km_zeroize, 1);
    r0 = rsp_count; a0 = acc_count;
    @(negedge clk);
    zeroize = 1'b0;
    #1;
    check_eq("zer_idle", {cmd_ready, busy}, 2'b10);
    check_eq("zer_key_valid", key_valid, 0);
    check_eq("zer_rsp_valid", rsp_valid, 0);
    @(negedge clk); #3;
    check_eq("zer_reaccept", acc_count - a0, 1);
    check_eq("zer_km_init", km_init, 1);
    check_eq("zer_no_rsp", rsp_count - r0, 0);
    cmd_valid = 1'b0;
    km_hold = 1'b0;
    wait_rsp("zer_init", 40);
    check_eq("zer_init_lat", rsp_cyc - acc_edge, 21);
    check_eq("zer_init_err", rsp_err_s, 0);

    // Reserved op.
    issue(2'd3, 1'b0, 1'b0);
    check_eq("rsvd_rsp", {rsp_valid, rsp_error}, 2'b11);
    check_eq("rsvd_key_valid", key_valid, 1);
    @(negedge clk); #1;
    check_eq("rsvd_cmd_ready", cmd_ready, 1);

    // ENC with cmd_valid held through the whole block.
    a0 = acc_count; e0 = enc_pulses;
    issue(2'd1, 1'b0, 1'b1);
    wait_rsp("enc", 20);
    check_eq("enc_rsp_lat", rsp_cyc - acc_edge, ENC_LAT + 3);
    check_eq("enc_rsp_err", rsp_err_s, 0);
    check_eq("enc_single_accept", acc_count - a0, 1);
    cmd_valid = 1'b0;
    @(negedge clk); #3;
    check_eq("enc_after_accept", acc_count - a0, 1);
    check_eq("enc_cmd_ready", cmd_ready, 1);
    check_eq("enc_pulses", enc_pulses - e0, 1);

    // Zeroize in IDLE wipes a valid 256-bit key.
    @(negedge clk);
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    #1;
    check_eq("zidle_key_valid", key_valid, 0);
    check_eq("zidle_keylen", km_keylen, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
